// File: rtl/eth_tx_arb_pkg.sv
// Shared types and defaults for the Ethernet TX frame arbiter.
package eth_tx_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_GAP   = 2'd3
   } arb_state_e;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   localparam int DEF_N_CH       = 2;
   localparam int DEF_IFG_CYCLES = 12;
   localparam int DEF_MAX_FRAME  = 1518;

   // Width of a counter that must hold 0..max_val, never narrower than 1 bit.
   function automatic int cnt_w(input int max_val);
      return (max_val > 0) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/eth_rr_pick.sv
// Combinational picker: lowest requesting index (fixed) or first requester after ptr (round-robin).
module eth_rr_pick
   import eth_tx_arb_pkg::*;
#(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
)(
   input  logic [N-1:0]  i_req,
   input  logic [IW-1:0] i_ptr,
   input  arb_mode_e     i_mode,
   output logic          o_found,
   output logic [N-1:0]  o_onehot,
   output logic [IW-1:0] o_idx
);

   int            w_start;
   logic [IW-1:0] w_i;

   always_comb begin
      o_found  = 1'b0;
      o_onehot = '0;
      o_idx    = '0;
      w_i      = '0;
      w_start  = (i_mode == ARB_RR) ? int'(i_ptr) + 1 : 0;
      for (int k = 0; k < N; k++) begin
         w_i = IW'((w_start + k) % N);
         if (!o_found && i_req[w_i]) begin
            o_found = 1'b1;
            o_idx   = w_i;
         end
      end
      o_onehot[o_idx] = o_found;
   end

endmodule

// File: rtl/eth_tx_arbiter.sv
// N-channel frame-level TX arbiter feeding the MAC byte port; grant is locked for a whole frame.
module eth_tx_arbiter
   import eth_tx_arb_pkg::*;
#(
   parameter int N_CH       = DEF_N_CH,
   parameter int IFG_CYCLES = DEF_IFG_CYCLES,
   parameter int MAX_FRAME  = DEF_MAX_FRAME
)(
   input  logic                 clk_tx_i,
   input  logic                 rst_n,
   input  logic                 mode_rr_i,
   input  logic [N_CH-1:0]      src_valid_i,
   input  logic [N_CH-1:0][7:0] src_data_i,
   output logic [N_CH-1:0]      src_ack_o,
   output logic                 mac_tx_valid_o,
   output logic [7:0]           mac_tx_data_o,
   input  logic                 mac_tx_ack_i,
   output logic [N_CH-1:0]      grant_o,
   output logic                 busy_o,
   output logic                 timeout_o
);

   localparam int            IW       = $clog2(N_CH);
   localparam int            CW       = cnt_w(MAX_FRAME);
   localparam int            GW       = cnt_w(IFG_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_FRAME);
   localparam logic [GW-1:0] GAP_LAST = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
   localparam arb_state_e    ST_AFTER = (IFG_CYCLES > 0) ? ST_GAP : ST_IDLE;

   arb_state_e      r_state;
   logic [N_CH-1:0] r_grant;
   logic [IW-1:0]   r_gidx;
   logic [IW-1:0]   r_rr_ptr;
   logic [CW-1:0]   r_cnt;
   logic [GW-1:0]   r_gap;
   logic            r_timeout;

   logic            w_found;
   logic [N_CH-1:0] w_pick_oh;
   logic [IW-1:0]   w_pick_idx;
   logic            w_src_vld;
   logic            w_at_max;
   logic            w_mac_vld;
   logic            w_xfer;

   eth_rr_pick #(.N(N_CH), .IW(IW)) u_pick (
      .i_req    (src_valid_i),
      .i_ptr    (r_rr_ptr),
      .i_mode   (arb_mode_e'(mode_rr_i)),
      .o_found  (w_found),
      .o_onehot (w_pick_oh),
      .o_idx    (w_pick_idx)
   );

   assign w_src_vld = src_valid_i[r_gidx];
   assign w_at_max  = (r_cnt == CNT_MAX);
   // At the byte limit the MAC is starved for the abort cycle so no byte past MAX_FRAME leaks out.
   assign w_mac_vld = (r_state == ST_BUSY) && w_src_vld && !w_at_max;
   assign w_xfer    = w_mac_vld && mac_tx_ack_i;

   always_comb begin
      src_ack_o = '0;
      if (w_xfer)
         src_ack_o[r_gidx] = 1'b1;
      else if (r_state == ST_DRAIN)
         src_ack_o[r_gidx] = w_src_vld;
   end

   assign mac_tx_valid_o = w_mac_vld;
   assign mac_tx_data_o  = (r_state == ST_BUSY) ? src_data_i[r_gidx] : 8'h00;
   assign grant_o        = r_grant;
   assign busy_o         = (r_state != ST_IDLE);
   assign timeout_o      = r_timeout;

   always_ff @(posedge clk_tx_i or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_grant   <= '0;
         r_gidx    <= '0;
         r_rr_ptr  <= IW'(N_CH - 1);
         r_cnt     <= '0;
         r_gap     <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_grant  <= w_pick_oh;
                  r_gidx   <= w_pick_idx;
                  r_rr_ptr <= w_pick_idx;
                  r_state  <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!w_src_vld) begin
                  r_grant <= '0;
                  r_cnt   <= '0;
                  r_state <= ST_AFTER;
               end else if (w_at_max) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_DRAIN;
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DRAIN: begin
               if (!w_src_vld) begin
                  r_grant <= '0;
                  r_cnt   <= '0;
                  r_state <= ST_AFTER;
               end
            end
            ST_GAP: begin
               if (r_gap == GAP_LAST) begin
                  r_gap   <= '0;
                  r_state <= ST_IDLE;
               end else begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Randomized bench for eth_tx_arbiter: source models push expected frames, a negedge monitor checks them.
module tb_eth_tx_arbiter;

   localparam int NCH  = 3;
   localparam int IFG  = 12;
   localparam int MAXF = 16;

   logic                clk     = 1'b0;
   logic                rst_n   = 1'b0;
   logic                mode_rr = 1'b0;
   logic                mac_ack = 1'b0;
   logic [NCH-1:0]      src_valid = '0;
   logic [NCH-1:0][7:0] src_data  = '0;
   logic [NCH-1:0]      src_ack;
   logic [NCH-1:0]      grant;
   logic                mac_valid;
   logic [7:0]          mac_data;
   logic                busy;
   logic                timeout;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   eth_tx_arbiter #(.N_CH(NCH), .IFG_CYCLES(IFG), .MAX_FRAME(MAXF)) dut (
      .clk_tx_i       (clk),
      .rst_n          (rst_n),
      .mode_rr_i      (mode_rr),
      .src_valid_i    (src_valid),
      .src_data_i     (src_data),
      .src_ack_o      (src_ack),
      .mac_tx_valid_o (mac_valid),
      .mac_tx_data_o  (mac_data),
      .mac_tx_ack_i   (mac_ack),
      .grant_o        (grant),
      .busy_o         (busy),
      .timeout_o      (timeout)
   );

   // source models
   bit         s_act  [NCH];
   int         s_len  [NCH];
   int         s_pos  [NCH];
   int         s_wait [NCH];
   int         s_left [NCH];
   int         s_force[NCH];
   logic [7:0] s_seed [NCH];
   int         s_fix   = 0;
   int         ack_pct = 75;

   // scoreboard
   logic [7:0] exp_b[NCH][$];
   int         exp_l[NCH][$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [7:0] fbyte(input logic [7:0] seed, input int pos);
      return seed + 8'(pos * 5);
   endfunction

   // reference arbitration rule
   function automatic int pick(input logic [NCH-1:0] req, input bit rr, input int last);
      for (int k = 0; k < NCH; k++) begin
         int i;
         i = rr ? (last + 1 + k) % NCH : k;
         if (req[i]) return i;
      end
      return -1;
   endfunction

   task automatic start_frame(input int c);
      int len;
      if (s_force[c] > 0) begin
         len = s_force[c];
         s_force[c] = 0;
      end else if (s_fix > 0) len = s_fix;
      else len = $urandom_range(1, MAXF + 5);
      s_len[c]  = len;
      s_pos[c]  = 0;
      s_act[c]  = 1'b1;
      s_seed[c] = 8'($urandom);
      s_left[c]--;
      exp_l[c].push_back(len);
      for (int p = 0; p < len && p < MAXF; p++) exp_b[c].push_back(fbyte(s_seed[c], p));
   endtask

   task automatic drive();
      for (int c = 0; c < NCH; c++) begin
         src_valid[c] = s_act[c];
         src_data[c]  = s_act[c] ? fbyte(s_seed[c], s_pos[c]) : 8'h00;
      end
   endtask

   // one clock: consume acks seen mid-cycle, then update inputs just after the edge
   task automatic cycle();
      @(negedge clk);
      for (int c = 0; c < NCH; c++) begin
         if (rst_n && s_act[c] && src_ack[c]) begin
            s_pos[c]++;
            if (s_pos[c] == s_len[c]) begin
               s_act[c]  = 1'b0;
               s_wait[c] = $urandom_range(1, 3);
            end
         end
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (!s_act[c]) begin
            if (s_wait[c] > 0) s_wait[c]--;
            else if (s_left[c] > 0) start_frame(c);
         end
      end
      drive();
      mac_ack = ($urandom_range(0, 99) < ack_pct);
   endtask

   task automatic run_until_done(input string name, input int budget);
      bit done;
      int quiet;
      done  = 1'b0;
      quiet = 0;
      for (int n = 0; n < budget && !done; n++) begin
         cycle();
         quiet = (src_valid == '0 && !busy && s_left[0] == 0 && s_left[1] == 0 && s_left[2] == 0)
                 ? quiet + 1 : 0;
         if (quiet >= 3) done = 1'b1;
      end
      check(name, 32'(done), 32'd1);
   endtask

   task automatic clear_sources();
      for (int c = 0; c < NCH; c++) begin
         s_act[c]   = 1'b0;
         s_left[c]  = 0;
         s_wait[c]  = 0;
         s_force[c] = 0;
         exp_b[c].delete();
         exp_l[c].delete();
      end
      drive();
   endtask

   // monitor
   int             m_own = -1, m_len, m_xfer, m_drn, m_to, m_gap, m_win, m_last;
   bit             m_pend = 1'b0, m_gap_on = 1'b0;
   logic [NCH-1:0] m_exp;

   always @(negedge clk) begin
      if (!rst_n) begin
         m_own    = -1;
         m_pend   = 1'b0;
         m_gap_on = 1'b0;
         m_last   = NCH - 1;
      end else begin
         if (m_pend) begin
            check("grant", 32'(grant), 32'(m_exp));
            m_pend = 1'b0;
            if (m_exp != '0) begin
               m_own  = m_win;
               m_xfer = 0;
               m_drn  = 0;
               m_to   = 0;
               if (exp_l[m_own].size() > 0) m_len = exp_l[m_own].pop_front();
               else begin
                  m_len = 0;
                  check("frame_queued", 32'(exp_l[m_own].size()), 32'd1);
               end
            end
         end
         if (m_own >= 0) begin
            if (grant == '0) begin
               check("xfer_count", 32'(m_xfer), 32'((m_len < MAXF) ? m_len : MAXF));
               check("drain_count", 32'(m_drn), 32'((m_len > MAXF) ? m_len - MAXF : 0));
               check("timeout_count", 32'(m_to), 32'(m_len > MAXF));
               m_own    = -1;
               m_gap_on = 1'b1;
               m_gap    = 0;
            end else begin
               check("stray_ack", 32'(src_ack & ~grant), 32'd0);
               if (src_ack[m_own]) begin
                  if (mac_valid) begin
                     m_xfer++;
                     if (exp_b[m_own].size() > 0) check("mac_byte", 32'(mac_data), 32'(exp_b[m_own].pop_front()));
                     else check("byte_queued", 32'(exp_b[m_own].size()), 32'd1);
                  end else m_drn++;
               end
               if (timeout) m_to++;
            end
         end
         if (m_gap_on) begin
            if (busy && grant == '0) m_gap++;
            else begin
               check("gap_len", 32'(m_gap), 32'(IFG));
               m_gap_on = 1'b0;
            end
         end
         if (!busy) begin
            check("idle_outputs", {15'd0, grant, timeout, mac_valid, mac_data, src_ack}, 32'd0);
            m_win = pick(src_valid, mode_rr, m_last);
            m_exp = '0;
            if (m_win >= 0) begin
               m_exp[m_win] = 1'b1;
               m_last = m_win;
            end
            m_pend = 1'b1;
         end
      end
   end

   initial begin
      bit hit;
      clear_sources();
      // outputs must stay quiet under reset even with live requests
      src_valid = '1;
      mac_ack   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_outputs", {12'd0, grant, busy, timeout, mac_valid, mac_data, src_ack}, 32'd0);
      src_valid = '0;
      mac_ack   = 1'b0;
      rst_n     = 1'b1;

      // fixed priority: boundary lengths first, then random
      mode_rr    = 1'b0;
      s_force[0] = MAXF;
      s_force[1] = MAXF + 4;
      s_force[2] = 1;
      for (int c = 0; c < NCH; c++) s_left[c] = 8;
      run_until_done("fixed_done", 20000);

      // round-robin with continuous 4-byte frames
      mode_rr = 1'b1;
      s_fix   = 4;
      ack_pct = 100;
      for (int c = 0; c < NCH; c++) s_left[c] = 6;
      run_until_done("rr4_done", 20000);

      // round-robin, random lengths and ack gaps
      s_fix   = 0;
      ack_pct = 60;
      for (int c = 0; c < NCH; c++) s_left[c] = 6;
      run_until_done("rr_rand_done", 20000);

      // reset in the middle of a frame
      for (int c = 0; c < NCH; c++) s_left[c] = 3;
      s_force[2] = MAXF;
      hit = 1'b0;
      for (int n = 0; n < 2000 && !hit; n++) begin
         cycle();
         for (int c = 0; c < NCH; c++) if (grant[c] && s_pos[c] >= 3) hit = 1'b1;
      end
      check("mid_frame_reached", 32'(hit), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_outputs", {12'd0, grant, busy, timeout, mac_valid, mac_data, src_ack}, 32'd0);
      clear_sources();
      repeat (3) cycle();
      rst_n = 1'b1;

      // all channels request together after reset: RR pointer starts at N_CH-1
      for (int c = 0; c < NCH; c++) s_left[c] = 2;
      hit = 1'b0;
      for (int n = 0; n < 10 && !hit; n++) begin
         cycle();
         if (grant != '0) hit = 1'b1;
      end
      check("rr_after_reset", 32'(grant), 32'd1);
      run_until_done("post_reset_done", 20000);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
